mem_arbiter: RTL and testbench

Shares one unified, variable-latency memory port between the pipeline's instruction-fetch requester and its data-memory (load/store) requester. Sits between the InstFetch/memory-stage logic and the single external memory. Data accesses have priority, and a starvation limit guarantees fetch progress. Each requester sees a simple req/ready handshake it can stall on; a watchdog turns a missing memory acknowledge into a completed, flagged transaction.

---
 rtl/mips_mem_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared memory-side types and constants for the pipeline
// and the data-memory model.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

    // Access width codes; 3'b000 marks a fetch access.
    localparam logic [2:0] MODE_FETCH = 3'b000;
    localparam logic [2:0] MODE_BYTE  = 3'b001;
    localparam logic [2:0] MODE_HALF  = 3'b010;
    localparam logic [2:0] MODE_WORD  = 3'b011;
    localparam logic [2:0] MODE_BYTEU = 3'b101;
    localparam logic [2:0] MODE_HALFU = 3'b110;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals
// around the shared memory arbiter.
interface mem_arbiter_if;
    import mips_mem_pkg::*;

    logic              if_req;
    logic [WORD_W-1:0] if_addr;
    logic              if_ready;
    logic [WORD_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_write;
    logic [WORD_W-1:0] dm_addr;
    logic [WORD_W-1:0] dm_wdata;
    logic [2:0]        dm_mode;
    logic              dm_ready;
    logic [WORD_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_write;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [2:0]        mem_mode;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    logic              busy;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_write, dm_addr, dm_wdata, dm_mode,
        input  mem_ack, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata,
        output mem_req, mem_write, mem_addr, mem_wdata, mem_mode,
        output busy, bus_err
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_write, dm_addr, dm_wdata, dm_mode,
        output mem_ack, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata,
        input  mem_req, mem_write, mem_addr, mem_wdata, mem_mode,
        input  busy, bus_err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one variable-latency memory port, with
// data priority, a fetch starvation limit and an ack watchdog.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int MAX_WAIT     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] SLIM  = 4'(STARVE_LIMIT);
    localparam logic [7:0] WLAST = 8'(MAX_WAIT - 1);

    arb_state_t        state;
    logic [3:0]        starve_cnt;
    logic [7:0]        wait_cnt;
    logic              if_win;
    logic              done;
    logic [WORD_W-1:0] rdata_ret;

    assign if_win = bus.if_req &&
                    (!bus.dm_req || starve_cnt == SLIM);

    // Ack beats a watchdog expiry landing in the same cycle.
    assign done = bus.mem_ack || (wait_cnt == WLAST);

    assign rdata_ret = (bus.mem_ack && !bus.mem_write)
                     ? bus.mem_rdata : '0;

    assign bus.busy = (state != IDLE);

    // Arbitration, memory-side launch and completion handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_mode  <= '0;
            bus.if_ready  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_ready  <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.bus_err   <= 1'b0;
        end else begin
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (if_win) begin
                        state         <= IF_BUSY;
                        starve_cnt    <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_write <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                        bus.mem_mode  <= MODE_FETCH;
                    end else if (bus.dm_req) begin
                        state <= DM_BUSY;
                        if (!bus.if_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != SLIM)
                            starve_cnt <= starve_cnt + 4'd1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_write <= bus.dm_write;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        bus.mem_mode  <= bus.dm_mode;
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (done) begin
                        state         <= IDLE;
                        bus.mem_req   <= 1'b0;
                        bus.mem_write <= 1'b0;
                        if (!bus.mem_ack)
                            bus.bus_err <= 1'b1;
                        if (state == IF_BUSY) begin
                            bus.if_ready <= 1'b1;
                            bus.if_rdata <= rdata_ret;
                        end else begin
                            bus.dm_ready <= 1'b1;
                            bus.dm_rdata <= rdata_ret;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level
// reference model checked every cycle.
module tb_mem_arbiter;
    import mips_mem_pkg::*;

    localparam int MAX_WAIT     = 15;
    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic reset;
    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_WAIT     (MAX_WAIT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction at a time.
    bit        m_act = 0;
    bit        m_is_if = 0;
    bit        m_wr = 0;
    bit        m_err = 0;
    int        m_age = 0;
    int        m_starve = 0;
    bit [31:0] m_addr = 0;
    bit [31:0] m_wdata = 0;
    bit [2:0]  m_mode = 0;
    bit        e_if_rdy = 0;
    bit        e_dm_rdy = 0;
    bit [31:0] e_if_rd = 0;
    bit [31:0] e_dm_rd = 0;
    bit        m_log[$];

    task automatic deliver(input bit [31:0] val);
        m_act = 0;
        if (m_is_if) begin
            e_if_rdy = 1;
            e_if_rd  = val;
        end else begin
            e_dm_rdy = 1;
            e_dm_rd  = val;
        end
    endtask

    task automatic model_tick();
        bit fetch_first;
        e_if_rdy = 0;
        e_dm_rdy = 0;
        if (reset) begin
            m_act = 0;
            m_starve = 0;
            m_err = 0;
            m_age = 0;
            e_if_rd = 0;
            e_dm_rd = 0;
        end else if (m_act) begin
            m_age++;
            if (bus.mem_ack)
                deliver(m_wr ? 32'h0 : bus.mem_rdata);
            else if (m_age == MAX_WAIT) begin
                deliver(32'h0);
                m_err = 1;
            end
        end else if (bus.if_req || bus.dm_req) begin
            fetch_first = bus.if_req &&
                (!bus.dm_req || m_starve == STARVE_LIMIT);
            if (fetch_first) begin
                m_is_if = 1;
                m_wr = 0;
                m_addr = bus.if_addr;
                m_wdata = 0;
                m_mode = 0;
                m_starve = 0;
            end else begin
                m_is_if = 0;
                m_wr = bus.dm_write;
                m_addr = bus.dm_addr;
                m_wdata = bus.dm_wdata;
                m_mode = bus.dm_mode;
                if (bus.if_req)
                    m_starve = (m_starve + 1 > STARVE_LIMIT)
                             ? STARVE_LIMIT : m_starve + 1;
                else
                    m_starve = 0;
            end
            m_act = 1;
            m_age = 0;
            m_log.push_back(m_is_if);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_tick();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("mem_req", 32'(bus.mem_req), 32'(m_act));
        chk("busy", 32'(bus.busy), 32'(m_act));
        chk("bus_err", 32'(bus.bus_err), 32'(m_err));
        chk("if_ready", 32'(bus.if_ready), 32'(e_if_rdy));
        chk("dm_ready", 32'(bus.dm_ready), 32'(e_dm_rdy));
        if (m_act) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("mem_write", 32'(bus.mem_write), 32'(m_wr));
            chk("mem_mode", 32'(bus.mem_mode), 32'(m_mode));
        end
        if (e_if_rdy)
            chk("if_rdata", bus.if_rdata, e_if_rd);
        if (e_dm_rdy)
            chk("dm_rdata", bus.dm_rdata, e_dm_rd);
    end

    // Requester and memory responder behaviour.
    bit        if_hold = 0;
    bit        dm_hold = 0;
    int        ack_lat = 0;
    int        ack_cnt = 0;
    bit [31:0] rd_val = 0;

    task automatic step();
        @(negedge clk);
        if (bus.if_ready && !if_hold) bus.if_req = 1'b0;
        if (bus.dm_ready && !dm_hold) bus.dm_req = 1'b0;
        if (bus.mem_req) begin
            ack_cnt++;
            bus.mem_ack = (ack_lat != 0 && ack_cnt == ack_lat);
        end else begin
            ack_cnt = 0;
            bus.mem_ack = 1'b0;
        end
        bus.mem_rdata = rd_val;
    endtask

    int        cyc, reqhi, if_cnt, dm_cnt, if_at, dm_at;
    bit [31:0] if_rd, dm_rd;
    bit        if_busy, prev_req;
    bit        dut_log[$];

    task automatic clear_stats();
        cyc = 0; reqhi = 0; if_cnt = 0; dm_cnt = 0;
        if_at = -1; dm_at = -1; if_rd = 0; dm_rd = 0;
        if_busy = 1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            cyc++;
            if (bus.mem_req) reqhi++;
            if (bus.mem_req && !prev_req)
                dut_log.push_back(bus.mem_addr == bus.if_addr
                                  && bus.if_req);
            prev_req = bus.mem_req;
            if (bus.if_ready) begin
                if_cnt++;
                if (if_at < 0) if_at = cyc;
                if_rd = bus.if_rdata;
                if_busy = bus.busy;
            end
            if (bus.dm_ready) begin
                dm_cnt++;
                if (dm_at < 0) dm_at = cyc;
                dm_rd = bus.dm_rdata;
            end
        end
    endtask

    function automatic logic [9:0] pack10(input bit q[$]);
        logic [9:0] v = '0;
        for (int i = 0; i < 10; i++)
            if (i < q.size()) v[9-i] = q[i];
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 0);
        chk({tag, "_mem_write"}, 32'(bus.mem_write), 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_mem_mode"}, 32'(bus.mem_mode), 0);
        chk({tag, "_if_ready"}, 32'(bus.if_ready), 0);
        chk({tag, "_dm_ready"}, 32'(bus.dm_ready), 0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 0);
        chk({tag, "_dm_rdata"}, bus.dm_rdata, 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_bus_err"}, 32'(bus.bus_err), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_write = 0; bus.dm_addr = 0;
        bus.dm_wdata = 0; bus.dm_mode = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        prev_req = 0;
        clear_stats();
        run(3);
        chk_zero("reset");
        reset = 1'b0;
        run(2);

        // Fetch alone, ack in the third memory cycle.
        clear_stats();
        ack_lat = 3; rd_val = 32'h8C01_0004;
        bus.if_addr = 32'h40; bus.if_req = 1;
        run(8);
        chk("t1_reqhi", 32'(reqhi), 3);
        chk("t1_if_cnt", 32'(if_cnt), 1);
        chk("t1_if_at", 32'(if_at), 4);
        chk("t1_if_rdata", if_rd, 32'h8C01_0004);
        chk("t1_busy_at_ready", 32'(if_busy), 0);

        // Simultaneous fetch and load, zero-wait memory.
        clear_stats();
        ack_lat = 1; rd_val = 32'hA5A5_0001;
        bus.if_addr = 32'h10; bus.if_req = 1;
        bus.dm_addr = 32'h200; bus.dm_write = 0;
        bus.dm_mode = MODE_HALFU; bus.dm_req = 1;
        run(8);
        chk("t2_dm_at", 32'(dm_at), 2);
        chk("t2_if_at", 32'(if_at), 4);
        chk("t2_dm_rdata", dm_rd, 32'hA5A5_0001);
        chk("t2_if_rdata", if_rd, 32'hA5A5_0001);

        // Both held: fetch forced after four data grants.
        clear_stats();
        dut_log.delete(); m_log.delete();
        if_hold = 1; dm_hold = 1;
        bus.if_addr = 32'h1000; bus.if_req = 1;
        bus.dm_addr = 32'h2000; bus.dm_mode = MODE_WORD;
        bus.dm_req = 1;
        run(20);
        chk("t3_dut_grants", 32'(pack10(dut_log)), 32'h021);
        chk("t3_model_grants", 32'(pack10(m_log)), 32'h021);
        if_hold = 0; dm_hold = 0;
        run(10);
        chk("t3_drained", 32'(bus.if_req | bus.dm_req), 0);

        // Store never acknowledged: watchdog abort.
        clear_stats();
        ack_lat = 0;
        bus.dm_addr = 32'h300; bus.dm_write = 1;
        bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_mode = MODE_WORD;
        bus.dm_req = 1;
        run(20);
        chk("t4_reqhi", 32'(reqhi), 15);
        chk("t4_dm_cnt", 32'(dm_cnt), 1);
        chk("t4_dm_at", 32'(dm_at), 16);
        chk("t4_dm_rdata", dm_rd, 0);
        chk("t4_bus_err", 32'(bus.bus_err), 1);
        clear_stats();
        bus.mem_ack = 1;
        run(3);
        chk("t4_late_ready", 32'(if_cnt + dm_cnt), 0);
        chk("t4_late_req", 32'(reqhi), 0);
        chk("t4_err_sticky", 32'(bus.bus_err), 1);

        // Reset in the second wait cycle of a load.
        clear_stats();
        ack_lat = 0;
        bus.dm_addr = 32'h400; bus.dm_write = 0;
        bus.dm_mode = MODE_HALF; bus.dm_req = 1;
        run(2);
        chk("t5_req_before", 32'(bus.mem_req), 1);
        reset = 1; bus.dm_req = 0;
        run(1);
        chk_zero("t5");
        reset = 0;
        run(2);
        chk("t5_no_ready", 32'(dm_cnt), 0);
        clear_stats();
        ack_lat = 2; rd_val = 32'h0BAD_F00D;
        bus.dm_req = 1;
        run(6);
        chk("t5_retry_cnt", 32'(dm_cnt), 1);
        chk("t5_retry_at", 32'(dm_at), 3);
        chk("t5_retry_rdata", dm_rd, 32'h0BAD_F00D);

        // Ack on the watchdog's final cycle.
        clear_stats();
        ack_lat = MAX_WAIT; rd_val = 32'h1234_5678;
        bus.if_addr = 32'h80; bus.if_req = 1;
        run(20);
        chk("t6_reqhi", 32'(reqhi), 15);
        chk("t6_if_at", 32'(if_at), 16);
        chk("t6_if_rdata", if_rd, 32'h1234_5678);
        chk("t6_bus_err", 32'(bus.bus_err), 0);

        // Store whose request drops right after grant.
        clear_stats();
        ack_lat = 2; rd_val = 32'hFFFF_FFFF;
        bus.dm_addr = 32'h500; bus.dm_write = 1;
        bus.dm_wdata = 32'h55; bus.dm_mode = MODE_BYTE;
        bus.dm_req = 1;
        run(1);
        bus.dm_req = 0;
        run(5);
        chk("t7_dm_cnt", 32'(dm_cnt), 1);
        chk("t7_dm_at", 32'(dm_at), 3);
        chk("t7_dm_rdata", dm_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
